branch_target_buffer_assoc: RTL and testbench

Set-associative branch target buffer for the fetch stage; successor to the direct-mapped BTB.
- Adds parametrised associativity, partial tags and a per-entry 2-bit taken/not-taken counter.
- Adds tree pseudo-LRU replacement and a sequential flush engine.
- Fetch lookup (F) is combinational. Update from the resolving branch in Execute (E) is synchronous.

---
 rtl/branch_target_buffer_assoc_pkg.sv | 25 ++
 rtl/branch_target_buffer_assoc_plru.sv | 42 ++++
 rtl/branch_target_buffer_assoc.sv | 196 +++++++++++++++++++
 tb/tb_branch_target_buffer_assoc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_target_buffer_assoc_pkg.sv
// Shared types for the set-associative BTB: counter encoding, flush FSM states, counter helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package btb_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    typedef enum logic {IDLE, FLUSH} flush_state_t;

    // Saturating increment toward strongly-taken.
    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'b01);
    endfunction

    // Saturating decrement toward strongly-not-taken.
    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'b01);
    endfunction

endpackage

// File: rtl/branch_target_buffer_assoc_plru.sv
// Tree pseudo-LRU for one set: picks a victim (lowest invalid way first) and computes touched bits.
// Latency: purely combinational.
// Backpressure: none; caller decides whether to commit plru_o.
module btb_plru #(
    parameter int WAYS = 2,
    localparam int PW  = (WAYS > 1) ? WAYS - 1 : 1,
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [PW-1:0]   plru_i,
    input  logic [WW-1:0]   acc_way_i,
    input  logic [WAYS-1:0] valid_i,
    output logic [WW-1:0]   victim_o,
    output logic [PW-1:0]   plru_o
);

    logic [WW-1:0] tree_v;

    // Each tree bit points at the side holding the victim; touching a way points bits away from it.
    generate
        if (WAYS == 1) begin : g_w1
            assign tree_v = '0;
            assign plru_o = plru_i;
        end else if (WAYS == 2) begin : g_w2
            assign tree_v = plru_i[0];
            assign plru_o = ~acc_way_i[0];
        end else begin : g_w4
            assign tree_v = plru_i[0] ? {1'b1, plru_i[2]} : {1'b0, plru_i[1]};
            assign plru_o = {acc_way_i[1] ? ~acc_way_i[0] : plru_i[2],
                             acc_way_i[1] ? plru_i[1]     : ~acc_way_i[0],
                             ~acc_way_i[1]};
        end
    endgenerate

    // An invalid way always beats the tree choice; the lowest-numbered one wins.
    always_comb begin
        victim_o = tree_v;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) victim_o = WW'(w);
        end
    end

endmodule

// File: rtl/branch_target_buffer_assoc.sv
// Set-associative BTB with partial tags, 2-bit counters, tree PLRU and a sequential flush sweep.
// Latency: fetch lookup combinational; update and flush take effect at the next rising edge.
// Backpressure: none; updates arriving while the sweep runs are dropped. Optional BTB_PERF_CNT_EN adds counters.
module branch_target_buffer_assoc
    import btb_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int WAYS       = 2,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC_F,
    output logic        hit_F,
    output logic        taken_F,
    output logic [31:0] target_F,
    input  logic        update_en,
    input  logic [31:0] PC_E,
    input  logic        taken_E,
    input  logic [31:0] target_E,
    input  logic        flush_req,
    output logic        flush_busy
`ifdef BTB_PERF_CNT_EN
    ,
    output logic [31:0] lookup_cnt,
    output logic [31:0] hit_cnt,
    output logic [31:0] mispredict_cnt
`endif
);

    localparam int SETS = 2 ** INDEX_BITS;
    localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TOP  = TAG_BITS + INDEX_BITS + 1;

    logic [WAYS-1:0]     valid_q [SETS];
    logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
    logic [31:0]         tgt_q   [SETS][WAYS];
    ctr_t                ctr_q   [SETS][WAYS];
    logic [PW-1:0]       plru_q  [SETS];

    flush_state_t          state_q, state_d;
    logic [INDEX_BITS-1:0] fcnt_q, fcnt_d;

    logic [INDEX_BITS-1:0] idx_f, idx_e;
    logic [TAG_BITS-1:0]   tag_f, tag_e;
    logic                  hit_f_raw, e_hit;
    logic [31:0]           tgt_f, e_tgt;
    ctr_t                  ctr_f, e_ctr;
    logic [WW-1:0]         e_way, victim, acc_way;
    logic [PW-1:0]         plru_nxt;
    logic                  unused_pc;

    assign idx_f = PC_F[INDEX_BITS+1:2];
    assign tag_f = PC_F[TOP:INDEX_BITS+2];
    assign idx_e = PC_E[INDEX_BITS+1:2];
    assign tag_e = PC_E[TOP:INDEX_BITS+2];
    assign unused_pc = ^{PC_F[31:TOP+1], PC_F[1:0], PC_E[31:TOP+1], PC_E[1:0]};

    // Fetch-side tag compare; matches are unique so the last match is the only match.
    always_comb begin
        hit_f_raw = 1'b0;
        tgt_f     = '0;
        ctr_f     = CTR_WNT;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx_f][w] && tag_q[idx_f][w] == tag_f) begin
                hit_f_raw = 1'b1;
                tgt_f     = tgt_q[idx_f][w];
                ctr_f     = ctr_q[idx_f][w];
            end
        end
    end

    assign hit_F    = hit_f_raw & ~flush_busy;
    assign taken_F  = hit_F & ctr_f[1];
    assign target_F = hit_F ? tgt_f : 32'h0;

    // Execute-side tag compare, independent of the fetch port.
    always_comb begin
        e_hit = 1'b0;
        e_way = '0;
        e_tgt = '0;
        e_ctr = CTR_WNT;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx_e][w] && tag_q[idx_e][w] == tag_e) begin
                e_hit = 1'b1;
                e_way = WW'(w);
                e_tgt = tgt_q[idx_e][w];
                e_ctr = ctr_q[idx_e][w];
            end
        end
    end

    assign acc_way = e_hit ? e_way : victim;

    btb_plru #(.WAYS(WAYS)) u_plru (
        .plru_i    (plru_q[idx_e]),
        .acc_way_i (acc_way),
        .valid_i   (valid_q[idx_e]),
        .victim_o  (victim),
        .plru_o    (plru_nxt)
    );

    // Entry storage: flush sweep has priority, then training/allocation from Execute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w] <= '0;
                    tgt_q[s][w] <= '0;
                    ctr_q[s][w] <= CTR_WNT;
                end
            end
        end else if (flush_busy) begin
            valid_q[fcnt_q] <= '0;
            plru_q[fcnt_q]  <= '0;
        end else if (update_en) begin
            if (e_hit) begin
                ctr_q[idx_e][e_way] <= taken_E ? ctr_inc(e_ctr) : ctr_dec(e_ctr);
                if (taken_E) tgt_q[idx_e][e_way] <= target_E;
                plru_q[idx_e] <= plru_nxt;
            end else if (taken_E) begin
                valid_q[idx_e][victim] <= 1'b1;
                tag_q[idx_e][victim]   <= tag_e;
                tgt_q[idx_e][victim]   <= target_E;
                ctr_q[idx_e][victim]   <= CTR_WT;
                plru_q[idx_e]          <= plru_nxt;
            end
        end
    end

    // Flush FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Flush FSM next state: a request in either state (re)starts the sweep from set 0.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (flush_req) begin
            state_d = FLUSH;
            fcnt_d  = '0;
        end else if (state_q == FLUSH) begin
            if (fcnt_q == INDEX_BITS'(SETS - 1)) begin
                state_d = IDLE;
                fcnt_d  = '0;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Flush FSM outputs.
    always_comb begin
        flush_busy = (state_q == FLUSH);
    end

`ifdef BTB_PERF_CNT_EN
    logic [31:0] lookup_cnt_q, hit_cnt_q, mispredict_cnt_q;
    logic        e_pred, mispredict;

    assign e_pred     = e_hit & e_ctr[1];
    assign mispredict = (e_pred != taken_E) | (e_pred & taken_E & (e_tgt != target_E));

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_cnt_q     <= '0;
            hit_cnt_q        <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (!flush_busy && lookup_cnt_q != '1) lookup_cnt_q <= lookup_cnt_q + 1'b1;
            if (hit_F && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            if (update_en && !flush_busy && mispredict && mispredict_cnt_q != '1)
                mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
        end
    end

    assign lookup_cnt     = lookup_cnt_q;
    assign hit_cnt        = hit_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
`else
    logic unused_tgt;
    assign unused_tgt = ^e_tgt;
`endif

endmodule

// File: tb/tb_branch_target_buffer_assoc.sv
// Self-checking bench for branch_target_buffer_assoc (INDEX_BITS=4, WAYS=2, TAG_BITS=8).
// Latency: reference model predicts combinational lookup from state as of the last edge.
// Backpressure: n/a; directed scenarios followed by randomized traffic with occasional flush/reset.
module tb_branch_target_buffer_assoc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PC_F = 32'h0;
    logic        hit_F, taken_F, flush_busy;
    logic [31:0] target_F;
    logic        update_en = 1'b0;
    logic [31:0] PC_E = 32'h0;
    logic        taken_E = 1'b0;
    logic [31:0] target_E = 32'h0;
    logic        flush_req = 1'b0;

    int nvec = 0;
    int nerr = 0;

    branch_target_buffer_assoc #(.INDEX_BITS(4), .WAYS(2), .TAG_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PC_F       (PC_F),
        .hit_F      (hit_F),
        .taken_F    (taken_F),
        .target_F   (target_F),
        .update_en  (update_en),
        .PC_E       (PC_E),
        .taken_E    (taken_E),
        .target_E   (target_E),
        .flush_req  (flush_req),
        .flush_busy (flush_busy)
    );

    always #5 clk = ~clk;

    // Reference model: per set two entries plus the most recently used way.
    bit          mv   [16][2];
    int          mt   [16][2];
    logic [31:0] mg   [16][2];
    int          mc   [16][2];
    int          mmru [16];
    int          mfleft = 0;
    int          mfset  = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic void mreset();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 0; mt[s][w] = 0; mg[s][w] = 0; mc[s][w] = 1;
            end
            mmru[s] = 1;
        end
        mfleft = 0;
        mfset  = 0;
    endfunction

    function automatic void mlook(input logic [31:0] pc, output bit h, output bit t, output logic [31:0] g);
        int s, tg;
        s = int'((pc >> 2) & 15);
        tg = int'((pc >> 6) & 255);
        h = 0; t = 0; g = 0;
        if (mfleft == 0)
            for (int w = 0; w < 2; w++)
                if (mv[s][w] && mt[s][w] == tg) begin
                    h = 1; t = (mc[s][w] >= 2); g = mg[s][w];
                end
    endfunction

    function automatic void mupdate();
        int s, tg, hw, v;
        s = int'((PC_E >> 2) & 15);
        tg = int'((PC_E >> 6) & 255);
        hw = -1;
        for (int w = 0; w < 2; w++) if (mv[s][w] && mt[s][w] == tg) hw = w;
        if (hw >= 0) begin
            if (taken_E) begin
                mc[s][hw] = (mc[s][hw] < 3) ? mc[s][hw] + 1 : 3;
                mg[s][hw] = target_E;
            end else begin
                mc[s][hw] = (mc[s][hw] > 0) ? mc[s][hw] - 1 : 0;
            end
            mmru[s] = hw;
        end else if (taken_E) begin
            v = -1;
            for (int w = 1; w >= 0; w--) if (!mv[s][w]) v = w;
            if (v < 0) v = 1 - mmru[s];
            mv[s][v] = 1; mt[s][v] = tg; mg[s][v] = target_E; mc[s][v] = 2;
            mmru[s] = v;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mreset();
        else if (mfleft > 0) begin
            mv[mfset][0] = 0; mv[mfset][1] = 0; mmru[mfset] = 1;
            if (flush_req) begin mfset = 0; mfleft = 16; end
            else begin mfset++; mfleft--; end
        end else begin
            if (update_en) mupdate();
            if (flush_req) begin mfset = 0; mfleft = 16; end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin : cmp
        bit h, t;
        logic [31:0] g;
        mlook(PC_F, h, t, g);
        chk("m_hit", {31'b0, hit_F}, {31'b0, h});
        chk("m_taken", {31'b0, taken_F}, {31'b0, t});
        chk("m_target", target_F, g);
        chk("m_busy", {31'b0, flush_busy}, {31'b0, mfleft > 0});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        PC_E = pc; taken_E = tk; target_E = tg; update_en = 1'b1;
        cyc();
        update_en = 1'b0;
    endtask

    task automatic look(input string nm, input logic [31:0] pc, input logic h, input logic t, input logic [31:0] g);
        PC_F = pc;
        #1;
        chk({nm, "_hit"}, {31'b0, hit_F}, {31'b0, h});
        chk({nm, "_taken"}, {31'b0, taken_F}, {31'b0, t});
        chk({nm, "_target"}, target_F, g);
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] p;
        p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) p = p | 32'h0010_0000;
        return p;
    endfunction

    initial begin
        int n;
        repeat (2) cyc();
        // 1. reset state
        look("rst", 32'h100, 1'b0, 1'b0, 32'h0);
        chk("rst_busy", {31'b0, flush_busy}, 32'h0);
        rst_n = 1'b1;
        cyc();

        // 2. first allocation; F sees it one cycle later
        upd(32'h100, 1'b1, 32'h200);
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        look("alias", 32'h140, 1'b0, 1'b0, 32'h0);

        // 3. counter hysteresis
        upd(32'h100, 1'b0, 32'h0);
        look("nt1", 32'h100, 1'b1, 1'b0, 32'h200);
        upd(32'h100, 1'b0, 32'h0);
        look("nt2", 32'h100, 1'b1, 1'b0, 32'h200);
        upd(32'h100, 1'b1, 32'h200);
        look("tk1", 32'h100, 1'b1, 1'b0, 32'h200);
        upd(32'h100, 1'b1, 32'h200);
        look("tk2", 32'h100, 1'b1, 1'b1, 32'h200);

        // 4. replacement in set 0
        upd(32'h100, 1'b1, 32'h200);
        upd(32'h140, 1'b1, 32'h240);
        upd(32'h180, 1'b1, 32'h280);
        look("evict100", 32'h100, 1'b0, 1'b0, 32'h0);
        look("keep140", 32'h140, 1'b1, 1'b1, 32'h240);
        look("new180", 32'h180, 1'b1, 1'b1, 32'h280);

        // 5. flush sweep
        upd(32'h100, 1'b1, 32'h200);
        look("pop100", 32'h100, 1'b1, 1'b1, 32'h200);
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        n = 0;
        while (flush_busy && n < 40) begin
            chk("flush_hit", {31'b0, hit_F}, 32'h0);
            update_en = (n == 3);
            PC_E = 32'h300; taken_E = 1'b1; target_E = 32'h500;
            cyc();
            n++;
        end
        update_en = 1'b0;
        chk("flush_len", n, 16);
        look("fl100", 32'h100, 1'b0, 1'b0, 32'h0);
        look("fl300", 32'h300, 1'b0, 1'b0, 32'h0);

        // 6. same-cycle F/E conflict, then reset mid-flush
        upd(32'h100, 1'b1, 32'h200);
        PC_E = 32'h100; taken_E = 1'b1; target_E = 32'h400; update_en = 1'b1;
        look("conf_old", 32'h100, 1'b1, 1'b1, 32'h200);
        cyc();
        update_en = 1'b0;
        look("conf_new", 32'h100, 1'b1, 1'b1, 32'h400);
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        repeat (4) cyc();
        chk("fl5_busy", {31'b0, flush_busy}, 32'h1);
        #1 rst_n = 1'b0;
        #1 chk("rst_abort", {31'b0, flush_busy}, 32'h0);
        cyc();
        rst_n = 1'b1;
        look("post100", 32'h100, 1'b0, 1'b0, 32'h0);
        look("post180", 32'h180, 1'b0, 1'b0, 32'h0);

        // Randomized traffic checked by the compare process.
        repeat (3000) begin
            PC_F      = rpc();
            PC_E      = ($urandom_range(0, 3) == 0) ? PC_F : rpc();
            update_en = ($urandom_range(0, 9) < 6);
            taken_E   = ($urandom_range(0, 2) != 0);
            target_E  = $urandom;
            flush_req = ($urandom_range(0, 60) == 0);
            rst_n     = ($urandom_range(0, 400) != 0);
            cyc();
        end
        rst_n = 1'b1;
        update_en = 1'b0;
        flush_req = 1'b0;
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
